// File: rtl/mem_lsu.sv
// Load/store initiator between the core memory stage and a word-wide RAM without byte enables.
// Sub-word stores are read-modify-write; loads are sign/zero-extended; misaligned requests error out.
module mem_lsu #(
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [31:0]         req_addr,
    input  logic [BITWIDTH-1:0] req_wdata,
    output logic                resp_valid,
    output logic [BITWIDTH-1:0] resp_rdata,
    output logic                resp_err,
    output logic                ram_wen,
    output logic [31:0]         ram_wAddr,
    output logic [BITWIDTH-1:0] ram_wData,
    output logic                ram_ren,
    output logic [31:0]         ram_rAddr,
    input  logic [BITWIDTH-1:0] ram_rData
);

    typedef enum logic [2:0] {IDLE, ERR, WR, RD, RDW, RMR, RMW} state_t;

    state_t              state, state_d;
    logic [1:0]          lane_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [15:0]         store_q;
    logic [BITWIDTH-1:0] wout_q;
    logic [31:0]         waddr_q;
    logic [31:0]         raddr_q;
    logic                accept;
    logic                mis;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        return (size == 2'b11) || (size == 2'b01 && lane[0]) || (size == 2'b10 && lane != 2'b00);
    endfunction

    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] lane, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return uns ? {24'd0, b} : 32'(b);
            2'b01:   return uns ? {16'd0, h} : 32'(h);
            default: return w;
        endcase
    endfunction

    // Only byte and half sizes ever reach the merge; the rest of the word is kept as read.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] wd,
                                          input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] m;
        m = w;
        if (size == 2'b00) m[{lane, 3'b000} +: 8] = wd[7:0];
        else               m[{lane[1], 4'b0000} +: 16] = wd;
        return m;
    endfunction

    assign req_ready = rst && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign mis       = misaligned(req_size, req_addr[1:0]);

    always_comb begin
        state_d    = state;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        ram_wen    = 1'b0;
        ram_ren    = 1'b0;
        ram_wData  = wout_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (mis)                    state_d = ERR;
                    else if (!req_we)           state_d = RD;
                    else if (req_size == 2'b10) state_d = WR;
                    else                        state_d = RMR;
                end
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_d    = IDLE;
            end
            WR: begin
                ram_wen    = 1'b1;
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            RD: begin
                ram_ren = 1'b1;
                state_d = RDW;
            end
            RDW: begin
                resp_valid = 1'b1;
                resp_rdata = fmt_load(ram_rData, size_q, lane_q, uns_q);
                state_d    = IDLE;
            end
            RMR: begin
                ram_ren = 1'b1;
                state_d = RMW;
            end
            RMW: begin
                ram_wen    = 1'b1;
                ram_wData  = merge(ram_rData, store_q, size_q, lane_q);
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_wAddr = waddr_q;
    assign ram_rAddr = raddr_q;

    // RAM addresses and write data are registered at accept so they hold between transactions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            lane_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            store_q <= '0;
            wout_q  <= '0;
            waddr_q <= '0;
            raddr_q <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                lane_q  <= req_addr[1:0];
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                store_q <= req_wdata[15:0];
                if (!mis) begin
                    if (req_we) begin
                        waddr_q <= {req_addr[31:2], 2'b00};
                        if (req_size == 2'b10) wout_q <= req_wdata;
                    end
                    if (!req_we || req_size != 2'b10) raddr_q <= {req_addr[31:2], 2'b00};
                end
            end
            if (state == RMW) wout_q <= ram_wData;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: word RAM model, table vectors, multi-cycle corner sequences and
// randomized requests checked against an arithmetic reference of memory contents.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        ram_wen, ram_ren;
    logic [31:0] ram_wAddr, ram_wData, ram_rAddr, ram_rData;

    always #5 clk = ~clk;

    mem_lsu #(.BITWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_wen(ram_wen), .ram_wAddr(ram_wAddr), .ram_wData(ram_wData),
        .ram_ren(ram_ren), .ram_rAddr(ram_rAddr), .ram_rData(ram_rData)
    );

    // Word RAM with one-cycle read latency, aliased on address bits [9:2].
    logic [31:0] ram [0:255];
    logic        ram_clr;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
        end else if (ram_wen) begin
            ram[ram_wAddr[9:2]] <= ram_wData;
        end
        if (ram_ren) ram_rData <= ram[ram_rAddr[9:2]];
    end

    logic [31:0] ref_mem [0:255];
    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // Reference: architectural effect of one request on memory and the response it yields.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd, output int lat,
                         output int nw, output int nr, output logic [31:0] ww);
        int          sh;
        logic [31:0] w, v, mask;
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        rd = 0; lat = 1; nw = 0; nr = 0; ww = 0;
        if (err) return;
        w    = ref_mem[a[9:2]];
        sh   = (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
        mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        if (we) begin
            nw = 1;
            if (sz == 2'd2) w = wd;
            else begin
                nr = 1; lat = 2;
                w = (w & ~(mask << sh)) | ((wd & mask) << sh);
            end
            ref_mem[a[9:2]] = w;
            ww = w;
        end else begin
            nr = 1; lat = 2;
            if (sz == 2'd2) rd = w;
            else begin
                v = (w >> sh) & mask;
                if (!uns && sz == 2'd0 && v[7])  v = v | 32'hFFFFFF00;
                if (!uns && sz == 2'd1 && v[15]) v = v | 32'hFFFF0000;
                rd = v;
            end
        end
    endtask

    // Drives one request from a negedge and observes it until its response or a cycle budget.
    task automatic run_req(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic err, output logic [31:0] rd, output int lat,
                           output int nw, output int nr, output int both,
                           output logic [31:0] wa, output logic [31:0] ra, output logic [31:0] wdt);
        int cyc;
        bit done;
        err = 0; rd = 0; lat = -1; nw = 0; nr = 0; both = 0; wa = 0; ra = 0; wdt = 0;
        cyc = 0;
        while (!req_ready && cyc < 10) begin @(negedge clk); cyc++; end
        chk({nm, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
        req_addr = $urandom; req_wdata = $urandom;
        cyc = 0; done = 0;
        while (!done) begin
            @(negedge clk); cyc++;
            if (ram_wen) begin nw++; wa = ram_wAddr; wdt = ram_wData; end
            if (ram_ren) begin nr++; ra = ram_rAddr; end
            if (ram_wen && ram_ren) both++;
            if (resp_valid) begin lat = cyc; err = resp_err; rd = resp_rdata; done = 1; end
            else if (cyc >= 10) done = 1;
        end
    endtask

    task automatic do_and_check(input string nm, input logic we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                output logic oerr, output logic [31:0] ord);
        logic e_err; logic [31:0] e_rd, e_ww; int e_lat, e_nw, e_nr;
        logic [31:0] wa, ra, wdt; int lat, nw, nr, both;
        model(we, sz, uns, a, wd, e_err, e_rd, e_lat, e_nw, e_nr, e_ww);
        run_req(nm, we, sz, uns, a, wd, oerr, ord, lat, nw, nr, both, wa, ra, wdt);
        chk({nm, "_lat"}, lat, e_lat);
        chk({nm, "_err"}, 32'(oerr), 32'(e_err));
        chk({nm, "_rdata"}, ord, e_rd);
        chk({nm, "_nwen"}, nw, e_nw);
        chk({nm, "_nren"}, nr, e_nr);
        chk({nm, "_both"}, both, 0);
        if (e_nw != 0) begin
            chk({nm, "_waddr"}, wa, {a[31:2], 2'b00});
            chk({nm, "_wdata"}, wdt, e_ww);
        end
        if (e_nr != 0) chk({nm, "_raddr"}, ra, {a[31:2], 2'b00});
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
    } rq_t;

    initial begin
        vec_t        tbl[$];
        rq_t         bq[4];
        logic        o_err, e_err;
        logic [31:0] o_rd, e_rd, e_ww, v;
        int          e_lat, e_nw, e_nr, nacc, nresp, bad_resp, bad_wen;
        logic        exp_err_q[$];
        logic [31:0] exp_rd_q[$];
        bit          will_acc;

        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h102, 32'hFFFFFFA5, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1'b0, 32'h11A53344});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h102, 32'h0,        1'b0, 32'hFFFFFFA5});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h102, 32'h0,        1'b0, 32'h000000A5});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h104, 32'h0,        1'b0, 32'h0});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h106, 32'h12348001, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h104, 32'h0,        1'b0, 32'h80010000});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h106, 32'h0,        1'b0, 32'hFFFF8001});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h106, 32'h0,        1'b0, 32'h00008001});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h101, 32'h55555555, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h103, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h100, 32'h66666666, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd3, 1'b1, 32'h100, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1'b0, 32'h11A53344});

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        rst = 1'b0; ram_clr = 1'b1;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_flags", {28'd0, resp_valid, resp_err, ram_wen, ram_ren}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_waddr", ram_wAddr, 32'd0);
        chk("rst_wdata", ram_wData, 32'd0);
        chk("rst_raddr", ram_rAddr, 32'd0);
        ram_clr = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        foreach (tbl[i]) begin
            do_and_check($sformatf("tbl%0d", i), tbl[i].we, tbl[i].sz, tbl[i].uns,
                         tbl[i].a, tbl[i].wd, o_err, o_rd);
            chk($sformatf("tbl%0d_const_err", i), 32'(o_err), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_const_rdata", i), o_rd, tbl[i].rd);
        end

        // Back-to-back: req_valid stays high across four requests.
        bq[0] = '{1'b1, 2'd2, 1'b0, 32'h300, 32'h01020304};
        bq[1] = '{1'b1, 2'd1, 1'b0, 32'h302, 32'h0000BEEF};
        bq[2] = '{1'b0, 2'd2, 1'b0, 32'h301, 32'h0};
        bq[3] = '{1'b0, 2'd2, 1'b0, 32'h300, 32'h0};
        nacc = 0; nresp = 0;
        for (int cyc = 0; cyc < 40 && nresp < 4; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (exp_err_q.size() == 0) begin
                    chk("b2b_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    chk($sformatf("b2b%0d_err", nresp), 32'(resp_err), 32'(exp_err_q.pop_front()));
                    chk($sformatf("b2b%0d_rdata", nresp), resp_rdata, exp_rd_q.pop_front());
                end
                chk("b2b_ready_busy", 32'(req_ready), 32'd0);
                nresp++;
            end
            if (nacc < 4) begin
                req_valid = 1'b1; req_we = bq[nacc].we; req_size = bq[nacc].sz;
                req_unsigned = bq[nacc].uns; req_addr = bq[nacc].a; req_wdata = bq[nacc].wd;
            end else begin
                req_valid = 1'b0;
            end
            will_acc = req_valid && req_ready;
            @(posedge clk);
            if (will_acc) begin
                model(bq[nacc].we, bq[nacc].sz, bq[nacc].uns, bq[nacc].a, bq[nacc].wd,
                      e_err, e_rd, e_lat, e_nw, e_nr, e_ww);
                exp_err_q.push_back(e_err);
                exp_rd_q.push_back(e_rd);
                nacc++;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", nacc, 4);
        chk("b2b_responses", nresp, 4);
        chk("b2b_last_word", ref_mem[8'hC0], 32'hBEEF0304);

        // Reset asserted in the read phase of a byte store.
        do_and_check("pre_abort", 1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, o_err, o_rd);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h201; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_rmr", 32'(ram_ren), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_flags", {28'd0, resp_valid, resp_err, ram_wen, ram_ren}, 32'd0);
        chk("abort_raddr", ram_rAddr, 32'd0);
        chk("abort_waddr", ram_wAddr, 32'd0);
        chk("abort_wdata", ram_wData, 32'd0);
        bad_resp = 0; bad_wen = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) bad_resp++;
            if (ram_wen) bad_wen++;
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid) bad_resp++;
            if (ram_wen) bad_wen++;
        end
        chk("abort_no_resp", bad_resp, 0);
        chk("abort_no_wen", bad_wen, 0);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        chk("abort_ram_word", ram[8'h80], 32'hCAFEF00D);
        do_and_check("post_abort", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, o_err, o_rd);
        chk("post_abort_const", o_rd, 32'hCAFEF00D);

        // Randomized requests over a small aliased window to force read-modify-write overlap.
        for (int i = 0; i < 60; i++) begin
            v = $urandom;
            do_and_check($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         (v & 32'hFFFFFC00) | 32'($urandom_range(0, 47)), $urandom, o_err, o_rd);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator that sits between the core's memory stage and the word-wide data RAM.
- Converts byte, halfword and word loads/stores into word-aligned RAM read/write cycles.
- The RAM has no byte enables, so sub-word stores are done as read-modify-write.
- Loads are sign- or zero-extended; misaligned accesses return an error instead of touching memory.

Parameters:
BITWIDTH, 32, RAM data width; the block supports only 32.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
req_valid  input  1  core request valid.
req_ready  output  1  block can accept a request.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  input  32  byte address.
req_wdata  input  32  store data, LSB-justified.
resp_valid  output  1  single-cycle response pulse; no backpressure.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_err  output  1  misaligned or illegal-size access; qualified by resp_valid.
ram_wen  output  1  RAM write enable.
ram_wAddr  output  32  RAM write address, always {addr[31:2],2'b00}.
ram_wData  output  32  RAM write data.
ram_ren  output  1  RAM read enable.
ram_rAddr  output  32  RAM read address, always {addr[31:2],2'b00}.
ram_rData  input  32  RAM read data; valid the cycle after ram_ren is sampled high.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; request registers cleared.
  - resp_valid, resp_err, resp_rdata, ram_wen, ram_ren, ram_wAddr, ram_wData, ram_rAddr all 0.
  - req_ready is 0 while rst is low and 1 in IDLE after release.
  - Reset mid-operation aborts immediately: no pending write is issued and no response is produced.
- Registering:
  - Request is accepted when req_valid && req_ready. addr, size, we, unsigned and wdata are captured into registers.
  - All ram_* and resp_* outputs derive from state plus the captured registers and ram_rData. There is no combinational path from req_* to ram_*.
- Handshake:
  - req_ready = 1 only in IDLE; one outstanding request at a time.
  - req_* may change freely while req_ready = 0.
- Misalignment check on accept:
  - error if size = 11;
  - error if size = 01 and addr[0] = 1;
  - error if size = 10 and addr[1:0] != 0.
- States:
  - IDLE: wait for accept. Next state is ERR on misalignment, WR for a word store, RD for a load, RMR for a sub-word store.
  - ERR (1 cycle): resp_valid = 1, resp_err = 1, resp_rdata = 0; no RAM enable asserted. Next state IDLE.
  - WR (1 cycle): ram_wen = 1, ram_wData = wdata, resp_valid = 1. Next state IDLE.
  - RD (1 cycle): ram_ren = 1. Next state RDW.
  - RDW (1 cycle): format ram_rData and assert resp_valid = 1. Next state IDLE.
  - RMR (1 cycle): ram_ren = 1 at the word address. Next state RMW.
  - RMW (1 cycle): ram_wen = 1, ram_wData = merge(ram_rData), resp_valid = 1. Next state IDLE.
- Latency from accept edge to resp_valid:
  - ERR and WR: 1 cycle.
  - Load and sub-word store: 2 cycles.
  - Next accept is possible the cycle after the response.
- Load formatting (lane = addr[1:0]):
  - Byte: ram_rData[8*lane+7 : 8*lane].
  - Half: ram_rData[16*addr[1]+15 : 16*addr[1]].
  - Extended to 32 bits per req_unsigned. Word loads are passed through unchanged.
- Store merge:
  - Byte: lane addr[1:0] of the read word is replaced by wdata[7:0].
  - Half: half addr[1] is replaced by wdata[15:0].
  - All other bytes keep the value just read.
- Masters and enables:
  - This block is the sole master of the RAM, so the RMR→RMW pair is atomic.
  - ram_wen and ram_ren are never high in the same cycle.
  - Outside their active states, ram_* enables are 0. Addresses and data hold their last value.

Test Plan:
- Reset release, then word store addr 0x100 data 0xDEADBEEF → resp_valid 1 cycle after accept with resp_err = 0; ram_wen pulse with wAddr 0x100. Then word load 0x100 → resp_rdata 0xDEADBEEF, 2 cycles after accept.
- Byte store 0xA5 to 0x102 over word 0x11223344 → RMR then RMW; ram_wData 0x11A53344. Signed byte load from 0x102 → 0xFFFFFFA5; unsigned → 0x000000A5.
- Half store 0x8001 to 0x106 over word 0 → ram_wData 0x80010000. Signed half load from 0x106 → 0xFFFF8001; unsigned → 0x00008001.
- Misaligned cases (word at 0x101, half at 0x103, size 11) → resp_valid with resp_err = 1, resp_rdata 0, no ram_wen/ram_ren for the whole transaction.
- Back-to-back req_valid held high across 4 requests → req_ready low outside IDLE; exactly 4 responses, in order, with no dropped or duplicated accepts.
- Assert rst low during RMR of a byte store → RAM word is unchanged, no resp_valid, outputs go to 0 asynchronously; after release, req_ready = 1 and a fresh load returns the original word.
